// File: rtl/rvga_membus_mem.sv
// Word-addressed membus slave: one outstanding request, fixed LATENCY cycles from
// acceptance to a one-cycle resp_o pulse, backing store of DEPTH 32-bit words.
//
// state | meaning
// IDLE  | waiting for read_i/write_i; request latched on acceptance
// BUSY  | latency countdown, inputs ignored
// RESP  | resp_o high for this cycle; a latched write commits on the closing edge
module rvga_membus_mem #(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        resp_o,
  output logic        err_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH];

  // Byte-offset bits and bits above the array index alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:2+AW], addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      resp_o   <= 1'b0;
      rdata_o  <= 32'd0;
      err_o    <= 1'b0;
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else begin
      resp_o  <= 1'b0;
      rdata_o <= 32'd0;
      case (state)
        IDLE: begin
          if (read_i | write_i) begin
            idx_q   <= addr_i[2 +: AW];
            wdata_q <= wdata_i;
            wr_q    <= write_i;
            cnt     <= 4'(LATENCY - 1);
            if (read_i & write_i) err_o <= 1'b1;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_o <= 1'b1;
              if (!write_i) begin
                rdata_o  <= mem[addr_i[2 +: AW]];
                rd_cnt_o <= rd_cnt_o + 32'd1;
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= RESP;
            resp_o <= 1'b1;
            if (!wr_q) begin
              rdata_o  <= mem[idx_q];
              rd_cnt_o <= rd_cnt_o + 32'd1;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          if (wr_q) wr_cnt_o <= wr_cnt_o + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain; a reset mid-transaction drops the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state == RESP && wr_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_rvga_membus_mem.sv
// Bench for rvga_membus_mem: three instances (LATENCY 2, 1, 15) checked every cycle
// against a timestamp-based transaction model, plus directed literal checks.
module tb_rvga_membus_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] t_addr  [3];
  logic        t_rd    [3];
  logic        t_wr    [3];
  logic [31:0] t_wdata [3];
  logic [31:0] dut_rdata  [3];
  logic        dut_resp   [3];
  logic        dut_err    [3];
  logic [31:0] dut_rd_cnt [3];
  logic [31:0] dut_wr_cnt [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int lat(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      rvga_membus_mem #(
        .DEPTH(1024),
        .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .addr_i   (t_addr[g]),
        .read_i   (t_rd[g]),
        .write_i  (t_wr[g]),
        .wdata_i  (t_wdata[g]),
        .rdata_o  (dut_rdata[g]),
        .resp_o   (dut_resp[g]),
        .err_o    (dut_err[g]),
        .rd_cnt_o (dut_rd_cnt[g]),
        .wr_cnt_o (dut_wr_cnt[g])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction accepted at cycle t completes at cycle t+LATENCY; while one is
  // outstanding (including its response cycle) no new request is taken.
  int          cyc = 0;
  bit          mready = 1'b0;
  bit          mbusy [3];
  bit          mresp [3];
  bit          merr  [3];
  bit          mop_wr [3];
  bit          mrd_known [3];
  int          mdue  [3];
  logic [9:0]  midx  [3];
  logic [31:0] mwd   [3];
  logic [31:0] mexp_rd [3];
  int unsigned mrd [3];
  int unsigned mwr [3];
  logic [31:0] mmem [3][1024];
  bit          mval [3][1024];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mbusy[i] = 1'b0; mresp[i] = 1'b0; merr[i] = 1'b0;
        mrd[i] = 0; mwr[i] = 0;
      end else begin
        if (mbusy[i]) begin
          if (mresp[i]) begin
            mbusy[i] = 1'b0;
            if (mop_wr[i]) begin
              mmem[i][midx[i]] = mwd[i];
              mval[i][midx[i]] = 1'b1;
              mwr[i]++;
            end else begin
              mrd[i]++;
            end
          end
        end else if (t_rd[i] | t_wr[i]) begin
          mbusy[i]  = 1'b1;
          mdue[i]   = cyc + lat(i);
          mop_wr[i] = t_wr[i];
          midx[i]   = t_addr[i][11:2];
          mwd[i]    = t_wdata[i];
          if (t_rd[i] & t_wr[i]) merr[i] = 1'b1;
        end
        mresp[i] = mbusy[i] && (cyc + 1 == mdue[i]);
        mrd_known[i] = 1'b0;
        if (mresp[i] && !mop_wr[i]) begin
          mexp_rd[i]   = mmem[i][midx[i]];
          mrd_known[i] = mval[i][midx[i]];
        end
      end
    end
    if (rst) mready = 1'b1;
    cyc++;
  end

  always @(negedge clk) begin
    if (mready) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("resp[%0d]", i), 32'(dut_resp[i]), 32'(mresp[i]));
        chk($sformatf("err[%0d]", i), 32'(dut_err[i]), 32'(merr[i]));
        if (!mresp[i] || mop_wr[i])
          chk($sformatf("rdata_idle[%0d]", i), dut_rdata[i], 32'd0);
        else if (mrd_known[i])
          chk($sformatf("rdata[%0d]", i), dut_rdata[i], mexp_rd[i]);
        if (!mresp[i]) begin
          chk($sformatf("rd_cnt[%0d]", i), dut_rd_cnt[i], mrd[i]);
          chk($sformatf("wr_cnt[%0d]", i), dut_wr_cnt[i], mwr[i]);
        end
      end
    end
  end

  // Called at a negedge in an idle cycle; returns at a negedge in the following idle cycle.
  task automatic txn(input int i, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rv, output int n);
    t_addr[i] = a; t_rd[i] = r; t_wr[i] = w; t_wdata[i] = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin t_rd[i] = 1'b0; t_wr[i] = 1'b0; end
    end while (!dut_resp[i] && n < 40);
    rv = dut_rdata[i];
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] rv;
  int          n;
  logic [31:0] sb [256];
  int          waddr [100];

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_addr[i] = 32'd0; t_rd[i] = 1'b0; t_wr[i] = 1'b0; t_wdata[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_resp", 32'(dut_resp[0]), 32'd0);
    chk("reset_rdata", dut_rdata[0], 32'd0);
    chk("reset_err", 32'(dut_err[0]), 32'd0);
    chk("reset_rd_cnt", dut_rd_cnt[0], 32'd0);
    chk("reset_wr_cnt", dut_wr_cnt[0], 32'd0);

    // basic write then read, LATENCY=2
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rv, n);
    chk("t1_wr_lat", 32'(n), 32'd2);
    txn(0, 1'b1, 1'b0, 32'h10, 32'd0, rv, n);
    chk("t1_rd_lat", 32'(n), 32'd2);
    chk("t1_rdata", rv, 32'hDEADBEEF);
    chk("t1_wr_cnt", dut_wr_cnt[0], 32'd1);
    chk("t1_rd_cnt", dut_rd_cnt[0], 32'd1);

    // aliasing of upper and byte-offset address bits
    txn(0, 1'b0, 1'b1, 32'h0000_1004, 32'h1234, rv, n);
    txn(0, 1'b1, 1'b0, 32'h0000_0004, 32'd0, rv, n);
    chk("t2_alias_hi", rv, 32'h1234);
    txn(0, 1'b1, 1'b0, 32'h0000_0007, 32'd0, rv, n);
    chk("t2_alias_lo", rv, 32'h1234);

    // read held one cycle past resp -> duplicate transaction
    do_reset();
    t_addr[0] = 32'h10; t_rd[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!dut_resp[0] && n < 40);
    chk("t3_first_lat", 32'(n), 32'd2);
    @(negedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) t_rd[0] = 1'b0;
    end while (!dut_resp[0] && n < 40);
    chk("t3_second_lat", 32'(n), 32'd2);
    chk("t3_rdata", dut_rdata[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("t3_rd_cnt", dut_rd_cnt[0], 32'd2);

    // simultaneous read & write: treated as write, sticky error
    do_reset();
    txn(0, 1'b1, 1'b1, 32'h20, 32'h55, rv, n);
    chk("t4_lat", 32'(n), 32'd2);
    chk("t4_err", 32'(dut_err[0]), 32'd1);
    chk("t4_wr_cnt", dut_wr_cnt[0], 32'd1);
    chk("t4_rd_cnt", dut_rd_cnt[0], 32'd0);
    txn(0, 1'b1, 1'b0, 32'h20, 32'd0, rv, n);
    chk("t4_rdata", rv, 32'h55);
    chk("t4_err_held", 32'(dut_err[0]), 32'd1);
    do_reset();
    chk("t4_err_cleared", 32'(dut_err[0]), 32'd0);

    // reset during BUSY discards the write
    txn(0, 1'b0, 1'b1, 32'h40, 32'h77, rv, n);
    do_reset();
    t_addr[0] = 32'h40; t_wr[0] = 1'b1; t_wdata[0] = 32'hAA;
    @(negedge clk);
    t_wr[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_resp", 32'(dut_resp[0]), 32'd0);
      @(negedge clk);
    end
    chk("t5_wr_cnt", dut_wr_cnt[0], 32'd0);
    chk("t5_rd_cnt", dut_rd_cnt[0], 32'd0);
    txn(0, 1'b1, 1'b0, 32'h40, 32'd0, rv, n);
    chk("t5_rdata", rv, 32'h77);

    // random writes then reads on LATENCY=1 and LATENCY=15 instances
    for (int i = 1; i < 3; i++) begin
      do_reset();
      for (int k = 0; k < 100; k++) begin
        waddr[k] = $urandom_range(0, 255);
        sb[waddr[k]] = $urandom;
        txn(i, 1'b0, 1'b1, 32'(waddr[k]) << 2, sb[waddr[k]], rv, n);
        chk($sformatf("t6_wr_lat[%0d]", i), 32'(n), 32'(lat(i)));
      end
      for (int k = 0; k < 100; k++) begin
        int a;
        a = waddr[$urandom_range(0, 99)];
        txn(i, 1'b1, 1'b0, (32'(a) << 2) | 32'($urandom_range(0, 3)), 32'd0, rv, n);
        chk($sformatf("t6_rd_lat[%0d]", i), 32'(n), 32'(lat(i)));
        chk($sformatf("t6_rdata[%0d]", i), rv, sb[a]);
      end
      chk($sformatf("t6_wr_cnt[%0d]", i), dut_wr_cnt[i], 32'd100);
      chk($sformatf("t6_rd_cnt[%0d]", i), dut_rd_cnt[i], 32'd100);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
